knn_host_sequencer: RTL and testbench
=====================================

Name: knn_host_sequencer

Overview:
Host-side master for the kNN engine's register-wrapped interface. Takes a command (point count, k, compute wait) and a valid/ready word stream. Drives the engine's write/start/done/read strobes through the full load, query, compute and read-back sequence. Returns the k nearest results on a valid/ready result stream. Sits between the host DMA/stream fabric and the kNN register wrapper.

Parameters:
DATA_WIDTH, 32, width of data words and distance values
NUM_DIMS, 5, words per vector (training point or query)
RD_LATENCY, 2, cycles from knn_rd_en high to valid knn_name_out/knn_value_out (1 wrapper register + 1 engine)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cmd_go  in  1  one-cycle command strobe, accepted only in IDLE
cmd_num_points  in  32  number of training points
cmd_k  in  32  neighbours to return
cmd_wait  in  32  compute cycles to wait after start
s_data  in  DATA_WIDTH  training words then query words, dimension-major per point
s_valid  in  1  stream valid
s_ready  out  1  stream ready
knn_wr_en  out  1  engine write strobe
knn_data_in  out  DATA_WIDTH  engine write data
knn_done  out  1  one-cycle end-of-training-load marker
knn_start  out  1  one-cycle start strobe
knn_k  out  32  k presented to engine, held from accept to IDLE
knn_rd_en  out  1  one-cycle result read strobe
knn_name_out  in  32  engine result name
knn_value_out  in  DATA_WIDTH  engine result distance
r_name  out  32  result name
r_value  out  DATA_WIDTH  result distance
r_valid  out  1  result valid
r_ready  in  1  result ready
r_last  out  1  marks k-th result
busy  out  1  high in every state except IDLE
error  out  1  sticky; set on rejected command, cleared on next accepted cmd_go

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0. Reset mid-operation aborts immediately. No done/start pulse is emitted and in-flight reads are discarded.
- IDLE: cmd_go latches num_points, k and wait. If k == 0 or k > num_points, set error, issue no strobes and stay IDLE. Otherwise clear error and go to LOAD_TRAIN. If num_points == 0 the command is rejected by the k rule.
- LOAD_TRAIN: s_ready = 1. Each s_valid&&s_ready handshake gives knn_wr_en = 1 and knn_data_in = s_data in the same cycle (combinational pass-through, no stall toward the engine). A dimension counter runs 0..NUM_DIMS-1 and a point counter runs 0..num_points-1. After the last word of the last point, go to MARK_DONE.
- MARK_DONE: knn_done = 1 for exactly one cycle, s_ready = 0, then go to LOAD_QUERY.
- LOAD_QUERY: same handshake as LOAD_TRAIN for exactly NUM_DIMS words, then go to START.
- START: knn_start = 1 for one cycle. Load the wait counter with cmd_wait. Go to WAIT.
- WAIT: decrement each cycle. Go to READ in the cycle after the counter is 0. cmd_wait = 0 means READ follows START directly.
- READ: knn_rd_en = 1 for one cycle, then go to CAPTURE.
- CAPTURE: count RD_LATENCY cycles from the rd_en cycle. On the RD_LATENCY-th cycle, register knn_name_out/knn_value_out into r_name/r_value, set r_valid and go to PRESENT.
- PRESENT: hold r_name/r_value/r_valid stable until r_ready. r_last = 1 on result index k-1. On handshake, clear r_valid. If more results remain, go to READ; otherwise go to IDLE. The earliest next rd_en is the cycle after the handshake. At most one read is outstanding.
- cmd_go outside IDLE is ignored and does not set error.
- s_valid outside the LOAD states is not consumed (s_ready = 0).
- knn_wr_en, knn_done, knn_start and knn_rd_en are mutually exclusive in every cycle.
- Counters are 32-bit. A point count of up to 2^32-1 is legal, and there is no multiply (nested counters).

Decomposition:
- Shared package knn_pkg: state enum (IDLE, LOAD_TRAIN, MARK_DONE, LOAD_QUERY, START, WAIT, READ, CAPTURE, PRESENT) and the NUM_DIMS/DATA_WIDTH defaults.
- One natural sub-module, knn_vec_loader: the dimension/point nested counter with handshake. It is instantiated once and reused for both training and query loads by reloading the point count (1 for query).

Test Plan:
- num_points=3, k=2, wait=4, 20 words streamed with s_valid always high -> exactly 15 wr_en, one done, 5 wr_en, one start, then 4 idle cycles. Then rd_en, and r_valid exactly 2 cycles after rd_en, twice. r_last only on the second result.
- Same command with s_valid toggling every other cycle -> wr_en count and ordering unchanged. knn_data_in equals s_data on each handshake.
- k=0, then k=5 with num_points=3 -> error=1, busy stays 0, no strobes. A following valid cmd_go clears error.
- r_ready held low for 10 cycles on the first result -> r_name/r_value stable, no second rd_en until the handshake.
- Reset asserted in WAIT, and separately in CAPTURE -> next cycle all outputs 0 and state IDLE. A new command then completes normally.
- cmd_go pulsed during LOAD_TRAIN, and the wait=0 case -> the pulse is ignored, and rd_en occurs the cycle after start.

Source files
------------

// File: rtl/knn_pkg.sv
// knn_pkg: shared sequencer states and default widths for the kNN host side
package knn_pkg;
  localparam int KNN_DATA_WIDTH = 32;
  localparam int KNN_NUM_DIMS = 5;
  typedef enum logic [3:0] {
    IDLE,
    LOAD_TRAIN,
    MARK_DONE,
    LOAD_QUERY,
    START,
    WAIT,
    READ,
    CAPTURE,
    PRESENT
  } knn_state_t;
endpackage

// File: rtl/knn_vec_loader.sv
// knn_vec_loader: dimension/point nested counter that paces vector words into the engine
module knn_vec_loader #(
  parameter int NUM_DIMS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [31:0] num_points,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        wr_en,
  output logic        last
);
  logic [31:0] dim, pt;
  logic dim_end, pt_end;
  assign dim_end = dim == 32'(NUM_DIMS - 1);
  assign pt_end = pt == num_points - 32'd1;
  assign s_ready = active;
  assign wr_en = active && s_valid;
  assign last = wr_en && dim_end && pt_end;
  // step the dimension counter per word and the point counter per completed vector; both wrap to 0 after the last word
  always_ff @(posedge clk) begin
    if (reset) begin
      dim <= '0;
      pt <= '0;
    end else if (wr_en) begin
      dim <= dim_end ? 32'd0 : dim + 32'd1;
      pt <= dim_end ? (pt_end ? 32'd0 : pt + 32'd1) : pt;
    end
  end
endmodule

// File: rtl/knn_host_sequencer.sv
// knn_host_sequencer: host-side master driving the kNN engine through load, query, compute and read-back
module knn_host_sequencer
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH = KNN_DATA_WIDTH,
  parameter int NUM_DIMS = KNN_NUM_DIMS,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_go,
  input  logic [31:0]           cmd_num_points,
  input  logic [31:0]           cmd_k,
  input  logic [31:0]           cmd_wait,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  knn_wr_en,
  output logic [DATA_WIDTH-1:0] knn_data_in,
  output logic                  knn_done,
  output logic                  knn_start,
  output logic [31:0]           knn_k,
  output logic                  knn_rd_en,
  input  logic [31:0]           knn_name_out,
  input  logic [DATA_WIDTH-1:0] knn_value_out,
  output logic [31:0]           r_name,
  output logic [DATA_WIDTH-1:0] r_value,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  r_last,
  output logic                  busy,
  output logic                  error
);
  localparam logic [7:0] LAT_LAST = 8'(RD_LATENCY - 1);
  knn_state_t state, next_state;
  logic [31:0] num_points, k_r, wait_cnt, res_idx;
  logic [7:0] lat_cnt;
  logic err, ld_active, ld_wr, ld_last, cmd_ok, res_last, capture;
  assign cmd_ok = cmd_k != 32'd0 && cmd_k <= cmd_num_points;
  assign ld_active = state == LOAD_TRAIN || state == LOAD_QUERY;
  assign res_last = res_idx == k_r - 32'd1;
  assign capture = state == CAPTURE && lat_cnt == LAT_LAST;
  knn_vec_loader #(.NUM_DIMS(NUM_DIMS)) u_loader (
    .clk        (clk),
    .reset      (reset),
    .active     (ld_active),
    .num_points (state == LOAD_QUERY ? 32'd1 : num_points),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .wr_en      (ld_wr),
    .last       (ld_last)
  );
  assign knn_wr_en = ld_wr;
  assign knn_data_in = ld_wr ? s_data : '0;
  assign knn_done = state == MARK_DONE;
  assign knn_start = state == START;
  assign knn_rd_en = state == READ;
  assign busy = state != IDLE;
  assign knn_k = busy ? k_r : '0;
  assign error = err;
  assign r_last = r_valid && res_last;
  // next-state sequencing; the loader reports the final word of each load phase
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       next_state = (cmd_go && cmd_ok) ? LOAD_TRAIN : IDLE;
      LOAD_TRAIN: next_state = ld_last ? MARK_DONE : LOAD_TRAIN;
      MARK_DONE:  next_state = LOAD_QUERY;
      LOAD_QUERY: next_state = ld_last ? START : LOAD_QUERY;
      START:      next_state = wait_cnt == 32'd0 ? READ : WAIT;
      WAIT:       next_state = wait_cnt == 32'd1 ? READ : WAIT;
      READ:       next_state = CAPTURE;
      CAPTURE:    next_state = capture ? PRESENT : CAPTURE;
      PRESENT:    next_state = r_ready ? (res_last ? IDLE : READ) : PRESENT;
      default:    next_state = IDLE;
    endcase
  end
  // state register, command latch, wait/latency/result counters and the result holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      num_points <= '0;
      k_r <= '0;
      wait_cnt <= '0;
      res_idx <= '0;
      lat_cnt <= '0;
      err <= 1'b0;
      r_name <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && cmd_go) begin
        num_points <= cmd_num_points;
        k_r <= cmd_k;
        wait_cnt <= cmd_wait;
        res_idx <= '0;
        err <= !cmd_ok;
      end
      if (state == WAIT) wait_cnt <= wait_cnt - 32'd1;
      if (state == READ) lat_cnt <= 8'd1;
      if (state == CAPTURE) lat_cnt <= lat_cnt + 8'd1;
      if (capture) begin
        r_name <= knn_name_out;
        r_value <= knn_value_out;
        r_valid <= 1'b1;
      end
      if (state == PRESENT && r_ready) begin
        r_valid <= 1'b0;
        res_idx <= res_idx + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_knn_host_sequencer.sv
// tb_knn_host_sequencer: scoreboard bench for the kNN host sequencer with a simple engine model
module tb_knn_host_sequencer;
  typedef struct packed {
    logic [31:0] name;
    logic [31:0] value;
    logic        last;
  } res_t;

  logic clk = 0, reset = 1, cmd_go = 0, s_valid = 0, r_ready = 1;
  logic [31:0] cmd_num_points = 0, cmd_k = 0, cmd_wait = 0, s_data = 0;
  logic s_ready, knn_wr_en, knn_done, knn_start, knn_rd_en, r_valid, r_last, busy, error;
  logic [31:0] knn_data_in, knn_k, r_name, r_value;
  logic [31:0] knn_name_out = 0, knn_value_out = 0;

  int checks = 0, errors = 0;
  res_t rq[$];
  logic [31:0] dq[$];
  int exp_np = 0, exp_wait = 0, name_base = 0, eng_idx = 0;
  int wr_seen = 0, done_seen = 0, cyc = 0, start_cyc = 0, rd_cyc = 0, hs_cyc = 0;
  bit first_rd = 1, prev_rv = 0, prev_rdy = 0;
  logic [31:0] prev_name = 0, prev_value = 0;

  knn_host_sequencer dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go), .cmd_num_points(cmd_num_points),
    .cmd_k(cmd_k), .cmd_wait(cmd_wait), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .knn_wr_en(knn_wr_en), .knn_data_in(knn_data_in),
    .knn_done(knn_done), .knn_start(knn_start), .knn_k(knn_k), .knn_rd_en(knn_rd_en),
    .knn_name_out(knn_name_out), .knn_value_out(knn_value_out), .r_name(r_name),
    .r_value(r_value), .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // engine model: a read returns the next result one edge later and holds it
  always @(posedge clk) begin
    if (knn_rd_en) begin
      knn_name_out <= 32'(name_base + eng_idx);
      knn_value_out <= 32'hBEEF_0000 + 32'(name_base + eng_idx);
      eng_idx <= eng_idx + 1;
    end
  end

  // monitor: samples 2 time units after each falling edge, pops scoreboards and checks timing
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (reset) begin
      first_rd = 1;
      prev_rv = 0;
      prev_rdy = 0;
    end else begin
      chk("strobe_excl", 160'($countones({knn_wr_en, knn_done, knn_start, knn_rd_en}) <= 1 && !(knn_rd_en && r_valid)), 160'(1));
      if (knn_wr_en) begin
        if (dq.size() == 0) chk("wr_unexpected", 160'(knn_data_in), 160'(0) - 160'(1));
        else chk("wr_data", 160'({knn_data_in, s_data}), 160'({dq[0], dq[0]}));
        if (dq.size() != 0) void'(dq.pop_front());
        wr_seen++;
      end
      if (knn_done) begin
        chk("done_after_train", 160'(wr_seen), 160'(exp_np * 5));
        done_seen++;
      end
      if (knn_start) begin
        chk("start_after_query", 160'({wr_seen, done_seen}), 160'({32'(exp_np * 5 + 5), 32'd1}));
        start_cyc = cyc;
        first_rd = 1;
      end
      if (knn_rd_en) begin
        if (first_rd) chk("rd_after_wait", 160'(cyc - start_cyc), 160'(exp_wait + 1));
        else chk("rd_after_hs", 160'(cyc - hs_cyc), 160'(1));
        rd_cyc = cyc;
        first_rd = 0;
      end
      if (r_valid && !prev_rv) chk("rvalid_latency", 160'(cyc - rd_cyc), 160'(2));
      if (r_valid && prev_rv && !prev_rdy) chk("hold_stable", 160'({r_name, r_value}), 160'({prev_name, prev_value}));
      if (r_valid && r_ready) begin
        if (rq.size() == 0) chk("res_unexpected", 160'(r_name), 160'(0) - 160'(1));
        else chk("result", 160'({r_name, r_value, r_last}), 160'(rq.pop_front()));
        hs_cyc = cyc;
      end
      prev_rv = r_valid;
      prev_rdy = r_ready;
      prev_name = r_name;
      prev_value = r_value;
    end
  end

  function automatic bit cond(input int sel);
    case (sel)
      0: return knn_rd_en;
      1: return r_valid;
      default: return !busy;
    endcase
  endfunction

  task automatic poll(input string nm, input int sel);
    int t = 0;
    while (!cond(sel) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk({nm, "_timeout"}, 160'(0), 160'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    s_valid = 0;
    cmd_go = 0;
    @(negedge clk);
    chk("reset_outputs", 160'({s_ready, knn_wr_en, knn_data_in, knn_done, knn_start, knn_k, knn_rd_en,
        r_name, r_value, r_valid, r_last, busy, error}), 160'(0));
    reset = 0;
    rq.delete();
    dq.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input bit go);
    int t = 0;
    @(negedge clk);
    s_valid = 1;
    s_data = w;
    cmd_go = go;
    if (go) cmd_k = 0;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      cmd_go = 0;
      t++;
    end
    if (t >= 200) chk("stream_timeout", 160'(0), 160'(1));
  endtask

  task automatic reject(input int np, input int k);
    @(negedge clk);
    cmd_go = 1;
    cmd_num_points = 32'(np);
    cmd_k = 32'(k);
    cmd_wait = 3;
    @(negedge clk);
    cmd_go = 0;
    chk("reject_err", 160'({error, busy}), 160'(2'b10));
    repeat (4) begin
      @(negedge clk);
      chk("reject_quiet", 160'({busy, s_ready, knn_wr_en, knn_done, knn_start, knn_rd_en, knn_k, error}), 160'(1));
    end
  endtask

  // abort: 0 run to completion, 1 reset during WAIT, 2 reset during CAPTURE
  task automatic issue(input int id, input int np, input int k, input int wt,
                       input bit tog, input bit hold, input bit ign, input int abort);
    exp_np = np;
    exp_wait = wt;
    name_base = id * 100;
    eng_idx = 0;
    wr_seen = 0;
    done_seen = 0;
    for (int i = 0; i < k; i++)
      rq.push_back('{name: 32'(id * 100 + i), value: 32'hBEEF_0000 + 32'(id * 100 + i), last: (i == k - 1)});
    for (int j = 0; j < (np + 1) * 5; j++) dq.push_back((32'(id) << 24) | 32'(j));
    r_ready = !hold;
    @(negedge clk);
    cmd_go = 1;
    cmd_num_points = 32'(np);
    cmd_k = 32'(k);
    cmd_wait = 32'(wt);
    @(negedge clk);
    cmd_go = 0;
    chk("accept", 160'({busy, error, knn_k}), 160'({1'b1, 1'b0, 32'(k)}));
    for (int j = 0; j < (np + 1) * 5; j++) begin
      if (tog && (j % 2 == 1)) begin
        @(negedge clk);
        s_valid = 0;
      end
      send_word((32'(id) << 24) | 32'(j), ign && j == 3);
    end
    @(negedge clk);
    s_valid = 0;
    cmd_go = 0;
    if (abort == 1) begin
      do_reset();
      return;
    end
    if (abort == 2) begin
      poll("rd_en", 0);
      do_reset();
      return;
    end
    if (hold) begin
      poll("first_result", 1);
      repeat (10) @(negedge clk);
      r_ready = 1;
    end
    poll("cmd_complete", 2);
    @(negedge clk);
    chk("end_state", 160'({error, busy, knn_k}), 160'(0));
    chk("scoreboards_empty", 160'({rq.size(), dq.size()}), 160'(0));
  endtask

  initial begin
    do_reset();
    issue(1, 3, 2, 4, 0, 0, 0, 0);
    issue(2, 3, 2, 4, 1, 0, 0, 0);
    reject(3, 0);
    reject(3, 5);
    reject(0, 1);
    issue(3, 1, 1, 2, 0, 0, 0, 0);
    issue(4, 3, 3, 1, 0, 1, 0, 0);
    issue(5, 2, 1, 6, 0, 0, 0, 1);
    issue(6, 2, 2, 0, 0, 0, 0, 2);
    issue(7, 2, 2, 0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
